// File: rtl/bootram_loader.sv
// UART-fed boot RAM loader: parses SYNC/ADDR/LEN/DATA[/CKSUM] frames, writes the byte lanes, holds the CPU until a clean frame lands.
// Optional checksum byte and check: define BOOTRAM_LOADER_CKSUM_EN.
module bootram_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        ram_ce,
  output logic        ram_wre,
  output logic [3:0]  ram_lane,
  output logic [10:0] ram_ad,
  output logic [7:0]  ram_din,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN_H,
    S_LEN_L,
    S_DATA
`ifdef BOOTRAM_LOADER_CKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  state_t        state, state_n;
  logic [12:0]   addr, addr_n;
  logic [7:0]    len_hi, len_hi_n;
  logic [13:0]   remaining, remaining_n;
  logic [GW-1:0] gap, gap_n;
  logic [15:0]   len_word;
  logic          wr_n, done_n, err_n, hold_n;
  logic [3:0]    lane_n;
  logic [10:0]   ad_n;
  logic [7:0]    din_n;
`ifdef BOOTRAM_LOADER_CKSUM_EN
  logic [7:0]    sum, sum_n;
`endif

  assign len_word = {len_hi, rx_data};
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    len_hi_n    = len_hi;
    remaining_n = remaining;
    gap_n       = gap;
    wr_n        = 1'b0;
    lane_n      = '0;
    ad_n        = '0;
    din_n       = '0;
    done_n      = 1'b0;
    err_n       = err;
    hold_n      = cpu_hold;
`ifdef BOOTRAM_LOADER_CKSUM_EN
    sum_n       = sum;
`endif
    if (state == S_IDLE) begin
      gap_n = '0;
      if (rx_valid && rx_data == SYNC_BYTE) begin
        err_n   = 1'b0;
        hold_n  = 1'b1;
        state_n = S_ADDR_H;
`ifdef BOOTRAM_LOADER_CKSUM_EN
        sum_n   = '0;
`endif
      end
    end else if (rx_valid) begin
      // An arriving byte always beats a simultaneous timeout expiry.
      gap_n = '0;
`ifdef BOOTRAM_LOADER_CKSUM_EN
      sum_n = sum + rx_data;
`endif
      case (state)
        S_ADDR_H: begin
          addr_n[12:8] = rx_data[4:0];
          state_n      = S_ADDR_L;
        end
        S_ADDR_L: begin
          addr_n[7:0] = rx_data;
          state_n     = S_LEN_H;
        end
        S_LEN_H: begin
          len_hi_n = rx_data;
          state_n  = S_LEN_L;
        end
        S_LEN_L: begin
          if (len_word > 16'd8192) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else if (len_word == 16'd0) begin
`ifdef BOOTRAM_LOADER_CKSUM_EN
            state_n = S_CKSUM;
`else
            done_n  = 1'b1;
            hold_n  = 1'b0;
            state_n = S_IDLE;
`endif
          end else begin
            remaining_n = len_word[13:0];
            state_n     = S_DATA;
          end
        end
        S_DATA: begin
          wr_n        = 1'b1;
          lane_n      = 4'b0001 << addr[1:0];
          ad_n        = addr[12:2];
          din_n       = rx_data;
          addr_n      = addr + 13'd1;
          remaining_n = remaining - 14'd1;
          if (remaining == 14'd1) begin
`ifdef BOOTRAM_LOADER_CKSUM_EN
            state_n = S_CKSUM;
`else
            done_n  = 1'b1;
            hold_n  = 1'b0;
            state_n = S_IDLE;
`endif
          end
        end
`ifdef BOOTRAM_LOADER_CKSUM_EN
        S_CKSUM: begin
          state_n = S_IDLE;
          if (sum_n == 8'h00) begin
            done_n = 1'b1;
            hold_n = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end
`endif
        default: state_n = S_IDLE;
      endcase
    end else if (gap == GW'(TIMEOUT_CYCLES - 1)) begin
      gap_n   = gap + GW'(1);
      err_n   = 1'b1;
      state_n = S_IDLE;
    end else begin
      gap_n = gap + GW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      len_hi    <= '0;
      remaining <= '0;
      gap       <= '0;
      ram_ce    <= 1'b0;
      ram_wre   <= 1'b0;
      ram_lane  <= '0;
      ram_ad    <= '0;
      ram_din   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_hold  <= 1'b1;
`ifdef BOOTRAM_LOADER_CKSUM_EN
      sum       <= '0;
`endif
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      len_hi    <= len_hi_n;
      remaining <= remaining_n;
      gap       <= gap_n;
      ram_ce    <= wr_n;
      ram_wre   <= wr_n;
      ram_lane  <= lane_n;
      ram_ad    <= ad_n;
      ram_din   <= din_n;
      done      <= done_n;
      err       <= err_n;
      cpu_hold  <= hold_n;
`ifdef BOOTRAM_LOADER_CKSUM_EN
      sum       <= sum_n;
`endif
    end
  end

endmodule

// File: tb/tb_bootram_loader.sv
// Self-checking bench for bootram_loader: frame table, latency/timeout/reset sequences, random frames vs. a frame-level model.
module tb_bootram_loader;
  localparam int unsigned TMO = 40;
`ifdef BOOTRAM_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        ram_ce, ram_wre, cpu_hold, busy, done, err;
  logic [3:0]  ram_lane;
  logic [10:0] ram_ad;
  logic [7:0]  ram_din;

  always #5 clk = ~clk;

  bootram_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_lane(ram_lane), .ram_ad(ram_ad),
    .ram_din(ram_din), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic        ce;
    logic        wre;
    logic [10:0] ad;
    logic [3:0]  lane;
    logic [7:0]  din;
  } wr_t;

  wr_t cap[$];
  wr_t expq[$];
  int  done_cnt = 0;
  int  total = 0;
  int  bad = 0;

  always @(negedge clk) begin
    wr_t w;
    if (ram_ce || ram_wre) begin
      w.ce = ram_ce; w.wre = ram_wre; w.ad = ram_ad; w.lane = ram_lane; w.din = ram_din;
      cap.push_back(w);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Builds the byte stream and the expected write list straight from the frame rules.
  task automatic run_frame(input logic [15:0] a16, input logic [15:0] len, input bit bad_ck,
                           input int unsigned gmax, input logic [7:0] seed);
    logic [7:0]  q[$];
    logic [7:0]  d, s;
    logic [12:0] a;
    wr_t         w;
    expq.delete();
    q.push_back(8'hA5);
    q.push_back(a16[15:8]);
    q.push_back(a16[7:0]);
    q.push_back(len[15:8]);
    q.push_back(len[7:0]);
    if (len <= 16'd8192) begin
      for (int i = 0; i < int'(len); i++) begin
        d = 8'(17 * (i + 1)) + seed;
        q.push_back(d);
        a = 13'((int'(a16[12:0]) + i) % 8192);
        w.ce = 1'b1; w.wre = 1'b1; w.ad = 11'(a / 4); w.lane = 4'(1 << (a % 4)); w.din = d;
        expq.push_back(w);
      end
      if (CK) begin
        s = 8'h00;
        for (int i = 1; i < q.size(); i++) s = s + q[i];
        q.push_back(8'(0 - s) + (bad_ck ? 8'd1 : 8'd0));
      end
    end
    cap.delete();
    done_cnt = 0;
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (i != q.size() - 1) idle_cycles($urandom_range(gmax, 0));
    end
    idle_cycles(3);
  endtask

  task automatic check_frame(input string tag, input int nwr, input bit e_err, input bit e_hold);
    int m = 0;
    int n;
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) if (cap[i] !== expq[i]) m++;
    chk($sformatf("%s.nwr", tag), cap.size(), nwr);
    chk($sformatf("%s.writes", tag), m, 0);
    chk($sformatf("%s.done", tag), done_cnt, e_err ? 0 : 1);
    chk($sformatf("%s.err", tag), err, e_err);
    chk($sformatf("%s.hold", tag), cpu_hold, e_hold);
    chk($sformatf("%s.busy", tag), busy, 0);
  endtask

  typedef struct {
    logic [15:0] a16;
    logic [15:0] len;
    bit          badck;
    logic [7:0]  seed;
    int          nwr;
    bit          e_err;
    bit          e_hold;
    logic [10:0] ad0;
    logic [3:0]  lane0;
  } vec_t;

  vec_t tv[8];

  initial begin
    logic [15:0] a16, len;
    logic [7:0]  b;
    bit          bk, e;

    tv[0] = '{16'h0010, 16'd4,    1'b0, 8'h00, 4,    1'b0, 1'b0, 11'd4,    4'b0001};
    tv[1] = '{16'h0010, 16'd4,    1'b1, 8'h00, 4,    CK,   CK,   11'd4,    4'b0001};
    tv[2] = '{16'h0010, 16'd4,    1'b0, 8'h00, 4,    1'b0, 1'b0, 11'd4,    4'b0001};
    tv[3] = '{16'h1FFF, 16'd2,    1'b0, 8'h99, 2,    1'b0, 1'b0, 11'd2047, 4'b1000};
    tv[4] = '{16'hFFFF, 16'd1,    1'b0, 8'h00, 1,    1'b0, 1'b0, 11'd2047, 4'b1000};
    tv[5] = '{16'h0000, 16'h2001, 1'b0, 8'h00, 0,    1'b1, 1'b1, 11'd0,    4'b0000};
    tv[6] = '{16'h0123, 16'd0,    1'b0, 8'h00, 0,    1'b0, 1'b0, 11'd0,    4'b0000};
    tv[7] = '{16'h0003, 16'h2000, 1'b0, 8'h5A, 8192, 1'b0, 1'b0, 11'd0,    4'b1000};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.hold", cpu_hold, 1);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.ce", {ram_ce, ram_wre}, 0);
    chk("rst.lane", ram_lane, 0);
    chk("rst.ad", ram_ad, 0);
    chk("rst.din", ram_din, 0);

    cap.delete();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b);
    end
    idle_cycles(3);
    chk("idle.nwr", cap.size(), 0);
    chk("idle.busy", busy, 0);
    chk("idle.hold", cpu_hold, 1);

    for (int i = 0; i < 8; i++) begin
      run_frame(tv[i].a16, tv[i].len, tv[i].badck, i % 3, tv[i].seed);
      check_frame($sformatf("vec%0d", i), tv[i].nwr, tv[i].e_err, tv[i].e_hold);
      if (tv[i].nwr > 0 && cap.size() > 0) begin
        chk($sformatf("vec%0d.ad0", i), cap[0].ad, tv[i].ad0);
        chk($sformatf("vec%0d.lane0", i), cap[0].lane, tv[i].lane0);
      end
    end

    // Write and completion latency, one byte at a time.
    cap.delete(); done_cnt = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
    rx_valid = 1'b1; rx_data = 8'h3C;
    @(negedge clk);
    chk("lat.pre_ce", ram_ce, 0);
    @(posedge clk); #1 rx_valid = 1'b0;
    @(negedge clk);
    chk("lat.ce", {ram_ce, ram_wre}, 2'b11);
    chk("lat.ad", ram_ad, 8);
    chk("lat.lane", ram_lane, 4'b0001);
    chk("lat.din", ram_din, 8'h3C);
    chk("lat.done", done, CK ? 0 : 1);
    chk("lat.hold", cpu_hold, CK ? 1 : 0);
    @(negedge clk);
    chk("lat.ce_after", ram_ce, 0);
    chk("lat.done_after", done, 0);
`ifdef BOOTRAM_LOADER_CKSUM_EN
    rx_valid = 1'b1; rx_data = 8'hA3;
    @(negedge clk);
    chk("latck.pre_done", done, 0);
    @(posedge clk); #1 rx_valid = 1'b0;
    @(negedge clk);
    chk("latck.done", done, 1);
    chk("latck.hold", cpu_hold, 0);
    @(negedge clk);
    chk("latck.done_after", done, 0);
`endif

    // A byte landing on the expiry cycle keeps the frame alive.
    cap.delete(); done_cnt = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    repeat (TMO - 1) @(posedge clk);
    #1;
    send_byte(8'h00);
    chk("race.busy", busy, 1);
    chk("race.err", err, 0);
    send_byte(8'h01); send_byte(8'h5B);
`ifdef BOOTRAM_LOADER_CKSUM_EN
    send_byte(8'hA4);
`endif
    idle_cycles(3);
    chk("race.nwr", cap.size(), 1);
    chk("race.done", done_cnt, 1);
    chk("race.err_end", err, 0);
    chk("race.hold", cpu_hold, 0);

    // Silent line aborts exactly TMO cycles after the last byte.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    chk("tmo.busy_before", busy, 1);
    chk("tmo.err_before", err, 0);
    @(negedge clk);
    chk("tmo.busy", busy, 0);
    chk("tmo.err", err, 1);
    chk("tmo.hold", cpu_hold, 1);

    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst2.err", err, 0);
    chk("rst2.hold", cpu_hold, 1);
    @(posedge clk); #1 reset = 1'b0;

    // Reset in the middle of the data phase.
    cap.delete(); done_cnt = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    send_byte(8'h33); send_byte(8'h44);
    idle_cycles(3);
    chk("midrst.nwr", cap.size(), 2);
    chk("midrst.hold", cpu_hold, 1);
    chk("midrst.err", err, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done_cnt, 0);

    for (int i = 0; i < 25; i++) begin
      a16 = 16'($urandom);
      if ($urandom_range(9, 0) == 0) len = 16'($urandom_range(65535, 8193));
      else len = 16'($urandom_range(24, 0));
      bk = 1'($urandom_range(1, 0));
      e  = (len > 16'd8192) || (CK && bk);
      run_frame(a16, len, bk, 3, 8'($urandom));
      check_frame($sformatf("rnd%0d", i), (len > 16'd8192) ? 0 : int'(len), e, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bootram_loader.md
# bootram_loader

Serial boot loader that fills the four 2K×8 byte-lane boot RAMs from a UART byte stream. It is the write-side client of the boot RAM port (ce/wre/ad/din). While loading, it holds the PicoRV32 in reset, then releases it once a complete, checksum-clean frame has been written. It sits between the UART receiver and the boot RAM lanes, and is muxed onto the RAM port only while `cpu_hold` is high.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 1000000: maximum idle gap between bytes inside a frame before the frame is aborted.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, new byte on `rx_data`. There is no backpressure; the block accepts a byte every cycle.
- `rx_data` in 8: received byte.
- `ram_ce` out 1: RAM clock enable for the write cycle.
- `ram_wre` out 1: RAM write enable.
- `ram_lane` out 4: one-hot byte-lane select. Lane = byte address[1:0].
- `ram_ad` out 11: word address = byte address[12:2].
- `ram_din` out 8: write data.
- `cpu_hold` out 1: CPU reset request and RAM port mux select.
- `busy` out 1: a frame is in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse on good frame completion.
- `err` out 1: sticky frame error, cleared when the next sync byte is accepted.

## Operation
- Frame format: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, then CKSUM if enabled.
- Start address: {ADDR_H[4:0], ADDR_L} gives a 13-bit byte address. ADDR_H[7:5] is ignored.
- Length: LEN is 16 bits. Valid range is 0..8192.
- States and transitions: IDLE → ADDR_H → ADDR_L → LEN_H → LEN_L → DATA → CKSUM → IDLE. Each transition consumes one byte.
- IDLE: non-SYNC bytes are discarded. A SYNC byte clears `err`, sets `cpu_hold`, and clears the checksum accumulator.
- LEN_L, LEN = 0: go directly to CKSUM, with no writes.
- LEN_L, LEN > 8192: set `err` and return to IDLE, with no writes.
- DATA: each byte produces one RAM write at the current address. The address then increments modulo 8192, so it wraps 8191 → 0. The remaining count decrements; when it reaches 0 the state moves to CKSUM.
- Checksum: an 8-bit accumulator sums every byte after SYNC, including CKSUM itself. A frame is good when the sum is 8'h00.
- Good frame: pulse `done` and clear `cpu_hold`.
- Bad checksum: set `err`. `cpu_hold` stays high. Data already written is not undone.
- Timeout: when not in IDLE, a gap counter resets on every `rx_valid`. When it reaches `TIMEOUT_CYCLES`, set `err` and go to IDLE. `cpu_hold` is unchanged.
- Reset mid-frame: everything returns to IDLE immediately and no further writes occur.

## Timing
- Reset values:
  - state IDLE
  - `cpu_hold`=1
  - `ram_ce`=`ram_wre`=0, `ram_lane`=0, `ram_ad`=0, `ram_din`=0
  - `busy`=0, `done`=0, `err`=0
- Write latency: a data byte on `rx_valid` at cycle N drives `ram_ce`=`ram_wre`=1, `ram_lane`, `ram_ad` and `ram_din` during cycle N+1 only. All are registered outputs.
- Back-to-back data bytes on consecutive cycles produce consecutive write cycles with no gaps.
- `done` and the falling edge of `cpu_hold` occur in cycle N+1 after the CKSUM byte arrives at cycle N.
- Timeout abort: `err` is registered at the same edge that sets the gap count to `TIMEOUT_CYCLES`.
- `rx_valid` in the same cycle as timeout expiry: the byte wins, and the counter clears.

## Configuration
- Macro: `BOOTRAM_LOADER_CKSUM_EN`.
- Defined: the CKSUM byte and check are as described above.
- Undefined:
  - No CKSUM state and no accumulator.
  - The frame completes after the last data byte, or immediately after LEN_L when LEN = 0.
  - `done` fires in cycle N+1 after that byte.
  - Checksum errors cannot occur.

## Test plan
- Reset, then idle: `cpu_hold`=1, `busy`=0, no `ram_ce` activity.
- Frame A5 00 10 00 04 11 22 33 44 plus a correct checksum: expect 4 writes.
  - `ram_ad`=4 on every write.
  - `ram_lane` = 0001, 0010, 0100, 1000 in turn.
  - `ram_din` = 11, 22, 33, 44 in turn.
  - `done` pulses and `cpu_hold` drops to 0.
- Same frame with the checksum off by 1: same 4 writes, `err`=1, `cpu_hold` stays 1. A following good frame clears `err`.
- Address wrap with A5 1F FF 00 02 AA BB:
  - AA goes to `ram_ad`=2047, lane 1000.
  - BB goes to `ram_ad`=0, lane 0001.
- LEN=8193 (20 01): `err`=1, no writes, back to IDLE. Also 3 bytes sent, then silence for `TIMEOUT_CYCLES`: `err`=1 and `busy`=0 exactly at expiry.
- Assert `reset` after 2 of 4 data bytes: no further writes; `cpu_hold`=1 and `err`=0 after reset.
